// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the core, loader and Data_Memory sides of the shared data-memory port.
// The arbiter takes the slave view; the pipeline/loader/memory environment takes the master view.
interface dmem_port_arbiter_if #(
  parameter int SIZE = 32
);
  logic            core_req;
  logic            core_we;
  logic [SIZE-1:0] core_addr;
  logic [SIZE-1:0] core_wdata;
  logic [1:0]      core_wr_strb;
  logic [2:0]      core_rd_strb;
  logic [SIZE-1:0] core_rdata;
  logic            core_stall;

  logic            ld_req;
  logic            ld_we;
  logic [SIZE-1:0] ld_addr;
  logic [SIZE-1:0] ld_wdata;
  logic [1:0]      ld_wr_strb;
  logic [2:0]      ld_rd_strb;
  logic            ld_lock;
  logic            ld_gnt;
  logic            ld_rvalid;
  logic [SIZE-1:0] ld_rdata;

  logic            mem_we0;
  logic [SIZE-1:0] mem_addr;
  logic [SIZE-1:0] mem_wdata;
  logic [1:0]      mem_wr_strb;
  logic [2:0]      mem_rd_strb;
  logic [SIZE-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, core_wr_strb, core_rd_strb,
    output core_rdata, core_stall,
    input  ld_req, ld_we, ld_addr, ld_wdata, ld_wr_strb, ld_rd_strb, ld_lock,
    output ld_gnt, ld_rvalid, ld_rdata,
    output mem_we0, mem_addr, mem_wdata, mem_wr_strb, mem_rd_strb,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata, core_wr_strb, core_rd_strb,
    input  core_rdata, core_stall,
    output ld_req, ld_we, ld_addr, ld_wdata, ld_wr_strb, ld_rd_strb, ld_lock,
    input  ld_gnt, ld_rvalid, ld_rdata,
    input  mem_we0, mem_addr, mem_wdata, mem_wr_strb, mem_rd_strb,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing the Data_Memory port between the M-stage and a loader master.
// Optional loader lock (burst ownership) is enabled by defining DMEM_ARB_LOCK_EN.
module dmem_port_arbiter #(
  parameter int SIZE   = 32,
  parameter int RD_LAT = 1
) (
  input logic                clk,
  input logic                rst,
  dmem_port_arbiter_if.slave bus
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] RD_WAIT = 1'b1;
  localparam logic [2:0] LAT_INIT = 3'(RD_LAT - 1);

  logic [0:0]      state;
  logic            owner;
  logic            last_gnt;
  logic [2:0]      lat_cnt;
  logic [SIZE-1:0] addr_q;
  logic [1:0]      wr_strb_q;
  logic [2:0]      rd_strb_q;
  logic [SIZE-1:0] core_rdata_q;
  logic [SIZE-1:0] ld_rdata_q;

  logic            lock_hold;
  logic            grant_core;
  logic            grant_ld;
  logic            issue;
  logic            issue_we;
  logic [SIZE-1:0] issue_addr;
  logic [SIZE-1:0] issue_wdata;
  logic [1:0]      issue_wr_strb;
  logic [2:0]      issue_rd_strb;
  logic            ret;
  logic            ret_core;
  logic            ret_ld;

`ifdef DMEM_ARB_LOCK_EN
  assign lock_hold = last_gnt & bus.ld_lock;
`else
  logic unused_lock;
  assign unused_lock = bus.ld_lock;
  assign lock_hold   = 1'b0;
`endif

  // Grant decision: only in IDLE; ties go to whoever did not win last time.
  always_comb begin
    grant_core = 1'b0;
    grant_ld   = 1'b0;
    if (!rst && state == IDLE) begin
      grant_core = bus.core_req & ~lock_hold & (~bus.ld_req | last_gnt);
      grant_ld   = bus.ld_req & ~grant_core;
    end
  end

  assign issue = grant_core | grant_ld;

  always_comb begin
    issue_we      = 1'b0;
    issue_addr    = '0;
    issue_wdata   = '0;
    issue_wr_strb = '0;
    issue_rd_strb = '0;
    if (grant_core) begin
      issue_we      = bus.core_we;
      issue_addr    = bus.core_addr;
      issue_wdata   = bus.core_wdata;
      issue_wr_strb = bus.core_wr_strb;
      issue_rd_strb = bus.core_rd_strb;
    end else if (grant_ld) begin
      issue_we      = bus.ld_we;
      issue_addr    = bus.ld_addr;
      issue_wdata   = bus.ld_wdata;
      issue_wr_strb = bus.ld_wr_strb;
      issue_rd_strb = bus.ld_rd_strb;
    end
  end

  assign ret      = ~rst & (state == RD_WAIT) & (lat_cnt == 3'd0);
  assign ret_core = ret & ~owner;
  assign ret_ld   = ret & owner;

  // Memory side: live command on issue, latched read command while waiting, zero otherwise.
  always_comb begin
    bus.mem_we0     = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.mem_wr_strb = '0;
    bus.mem_rd_strb = '0;
    if (issue) begin
      bus.mem_we0     = issue_we;
      bus.mem_addr    = issue_addr;
      bus.mem_wdata   = issue_wdata;
      bus.mem_wr_strb = issue_wr_strb;
      bus.mem_rd_strb = issue_rd_strb;
    end else if (!rst && state == RD_WAIT) begin
      bus.mem_addr    = addr_q;
      bus.mem_wr_strb = wr_strb_q;
      bus.mem_rd_strb = rd_strb_q;
    end
  end

  assign bus.core_stall = ~rst & bus.core_req & ~((grant_core & bus.core_we) | ret_core);
  assign bus.core_rdata = rst ? '0 : (ret_core ? bus.mem_rdata : core_rdata_q);
  assign bus.ld_gnt     = grant_ld;
  assign bus.ld_rvalid  = ret_ld;
  assign bus.ld_rdata   = rst ? '0 : (ret_ld ? bus.mem_rdata : ld_rdata_q);

  // Sequencer: a read parks the port in RD_WAIT until the memory latency has elapsed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= 1'b0;
      last_gnt     <= 1'b1;
      lat_cnt      <= 3'd0;
      addr_q       <= '0;
      wr_strb_q    <= '0;
      rd_strb_q    <= '0;
      core_rdata_q <= '0;
      ld_rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            last_gnt <= grant_ld;
            if (!issue_we) begin
              state     <= RD_WAIT;
              owner     <= grant_ld;
              lat_cnt   <= LAT_INIT;
              addr_q    <= issue_addr;
              wr_strb_q <= issue_wr_strb;
              rd_strb_q <= issue_rd_strb;
            end
          end
        end
        RD_WAIT: begin
          if (lat_cnt == 3'd0) begin
            state <= IDLE;
            if (owner) ld_rdata_q   <= bus.mem_rdata;
            else       core_rdata_q <= bus.mem_rdata;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural Data_Memory and a read-data scoreboard.
module tb_dmem_port_arbiter;
  localparam int SIZE   = 32;
  localparam int RD_LAT = 2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [31:0] exp_q[$];
  int          own_q[$];

  dmem_port_arbiter_if #(.SIZE(SIZE)) bus ();

  dmem_port_arbiter #(.SIZE(SIZE), .RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural Data_Memory: writes in the issue cycle, reads appear RD_LAT cycles later.
  logic [31:0] mem   [0:63];
  logic [31:0] rpipe [0:RD_LAT-1];
  always @(posedge clk) begin
    if (bus.mem_we0) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    rpipe[0] <= mem[bus.mem_addr[7:2]];
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign bus.mem_rdata = rpipe[RD_LAT-1];

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic core_load(input logic [31:0] a, input logic [31:0] exp, input string tag);
    int stalls;
    bit done;
    stalls = 0;
    done   = 1'b0;
    bus.core_req     = 1'b1;
    bus.core_we      = 1'b0;
    bus.core_addr    = a;
    bus.core_rd_strb = 3'b010;
    exp_q.push_back(exp);
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.core_stall) begin
        stalls++;
        check({tag, "_addr_held"}, bus.mem_addr, a);
        @(posedge clk); #1;
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      check({tag, "_timeout"}, {31'b0, bus.core_stall}, 32'h0);
      void'(exp_q.pop_front());
    end else begin
      check({tag, "_rdata"}, bus.core_rdata, exp_q.pop_front());
      check({tag, "_stall_cycles"}, stalls, RD_LAT);
    end
    @(posedge clk); #1;
    bus.core_req = 1'b0;
  endtask

  task automatic ld_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
    bit got;
    int lat;
    got = 1'b0;
    lat = 0;
    bus.ld_req     = 1'b1;
    bus.ld_we      = 1'b0;
    bus.ld_addr    = a;
    bus.ld_rd_strb = 3'b010;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.ld_gnt) begin
        got = 1'b1;
        check({tag, "_issue_addr"}, bus.mem_addr, a);
        check({tag, "_issue_we"}, {31'b0, bus.mem_we0}, 32'h0);
      end
      @(posedge clk); #1;
    end
    bus.ld_req = 1'b0;
    if (!got) begin
      check({tag, "_gnt_timeout"}, {31'b0, bus.ld_gnt}, 32'h1);
    end else begin
      exp_q.push_back(exp);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        lat++;
        @(negedge clk);
        if (bus.ld_rvalid) begin
          got = 1'b1;
          check({tag, "_rdata"}, bus.ld_rdata, exp_q.pop_front());
          check({tag, "_latency"}, lat, RD_LAT);
        end
        @(posedge clk); #1;
      end
      if (!got) begin
        check({tag, "_rvalid_timeout"}, {31'b0, bus.ld_rvalid}, 32'h1);
        void'(exp_q.pop_front());
      end else begin
        @(negedge clk);
        check({tag, "_rvalid_pulse"}, {31'b0, bus.ld_rvalid}, 32'h0);
        check({tag, "_rdata_held"}, bus.ld_rdata, exp);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] caddr [0:3];
    logic [31:0] laddr [0:3];
    logic [31:0] ldat  [0:3];
    int          ci;
    int          li;
    int          obs_own;
    int          exp_own;
    int          seen;

    checks = 0;
    errors = 0;
    bus.core_req = 0; bus.core_we = 0; bus.core_addr = 0; bus.core_wdata = 0;
    bus.core_wr_strb = 0; bus.core_rd_strb = 0;
    bus.ld_req = 0; bus.ld_we = 0; bus.ld_addr = 0; bus.ld_wdata = 0;
    bus.ld_wr_strb = 0; bus.ld_rd_strb = 0; bus.ld_lock = 0;

    do_reset();
    @(negedge clk);
    check("rst_core_stall", {31'b0, bus.core_stall}, 32'h0);
    check("rst_ld_gnt", {31'b0, bus.ld_gnt}, 32'h0);
    check("rst_ld_rvalid", {31'b0, bus.ld_rvalid}, 32'h0);
    check("rst_mem_we0", {31'b0, bus.mem_we0}, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_core_rdata", bus.core_rdata, 32'h0);
    check("rst_ld_rdata", bus.ld_rdata, 32'h0);
    @(posedge clk); #1;

    // Core store alone: written in the issue cycle, no stall.
    bus.core_req = 1; bus.core_we = 1; bus.core_addr = 32'h10;
    bus.core_wdata = 32'hDEADBEEF; bus.core_wr_strb = 2'b10;
    @(negedge clk);
    check("st_mem_we0", {31'b0, bus.mem_we0}, 32'h1);
    check("st_core_stall", {31'b0, bus.core_stall}, 32'h0);
    check("st_mem_addr", bus.mem_addr, 32'h10);
    check("st_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    check("st_mem_wr_strb", {30'b0, bus.mem_wr_strb}, 32'h2);
    @(posedge clk); #1;
    bus.core_req = 0; bus.core_we = 0;
    @(negedge clk);
    check("idle_mem_addr", bus.mem_addr, 32'h0);
    check("idle_mem_we0", {31'b0, bus.mem_we0}, 32'h0);
    @(posedge clk); #1;

    core_load(32'h10, 32'hDEADBEEF, "ld10");
    @(negedge clk);
    check("core_rdata_held", bus.core_rdata, 32'hDEADBEEF);
    check("noreq_no_stall", {31'b0, bus.core_stall}, 32'h0);
    @(posedge clk); #1;

    // Contention straight after reset: core wins the first tie, then strict alternation.
    do_reset();
    caddr[0] = 32'h14; caddr[1] = 32'h18; caddr[2] = 32'h1C; caddr[3] = 32'h1C;
    laddr[0] = 32'h20; laddr[1] = 32'h24; laddr[2] = 32'h28; laddr[3] = 32'h28;
    ldat[0]  = 32'h12345678; ldat[1] = 32'hA5A50024; ldat[2] = 32'h0; ldat[3] = 32'h0;
    ci = 0; li = 0;
    own_q.push_back(0); own_q.push_back(1); own_q.push_back(0); own_q.push_back(1);
    bus.core_we = 1; bus.ld_we = 1; bus.core_req = 1; bus.ld_req = 1;
    for (int k = 0; k < 4; k++) begin
      bus.core_addr  = caddr[ci];
      bus.core_wdata = 32'hC0000000 | caddr[ci];
      bus.ld_addr    = laddr[li];
      bus.ld_wdata   = ldat[li];
      @(negedge clk);
      obs_own = bus.ld_gnt ? 1 : ((bus.mem_we0 && !bus.core_stall) ? 0 : 2);
      exp_own = own_q.pop_front();
      check($sformatf("rr_owner_%0d", k), obs_own, exp_own);
      check($sformatf("rr_addr_%0d", k), bus.mem_addr, (exp_own == 1) ? laddr[li] : caddr[ci]);
      @(posedge clk); #1;
      if (obs_own == 1) li++;
      else if (obs_own == 0) ci++;
    end
    bus.core_req = 0; bus.ld_req = 0; bus.core_we = 0; bus.ld_we = 0;
    @(posedge clk); #1;

    core_load(32'h14, 32'hC0000014, "ld14");
    ld_read(32'h20, 32'h12345678, "ldr20");
    core_load(32'h18, 32'hC0000018, "ld18");

    // Reset while a loader read is in flight: the read is dropped.
    bus.ld_req = 1; bus.ld_we = 0; bus.ld_addr = 32'h24;
    @(negedge clk);
    check("rstrd_gnt", {31'b0, bus.ld_gnt}, 32'h1);
    @(posedge clk); #1;
    bus.ld_req = 0;
    rst = 1;
    @(negedge clk);
    check("rstrd_rvalid_during_rst", {31'b0, bus.ld_rvalid}, 32'h0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("rstrd_rvalid", {31'b0, bus.ld_rvalid}, 32'h0);
    check("rstrd_mem_addr", bus.mem_addr, 32'h0);
    check("rstrd_mem_rd_strb", {29'b0, bus.mem_rd_strb}, 32'h0);
    check("rstrd_ld_rdata", bus.ld_rdata, 32'h0);
    check("rstrd_core_rdata", bus.core_rdata, 32'h0);
    check("rstrd_mem_we0", {31'b0, bus.mem_we0}, 32'h0);
    @(posedge clk); #1;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.ld_rvalid) seen++;
      @(posedge clk); #1;
    end
    check("rstrd_no_late_rvalid", seen, 0);

    ld_read(32'h24, 32'hA5A50024, "ldr24");

`ifdef DMEM_ARB_LOCK_EN
    // Loader lock: after reset the loader owns last_gnt, so a locked burst shuts the core out.
    do_reset();
    bus.core_req = 1; bus.core_we = 1; bus.core_addr = 32'h30; bus.core_wdata = 32'h30303030;
    bus.ld_req = 1; bus.ld_we = 1; bus.ld_lock = 1;
    for (int k = 0; k < 4; k++) begin
      bus.ld_addr  = 32'h40 + 32'(4 * k);
      bus.ld_wdata = 32'hB0000000 + 32'(k);
      @(negedge clk);
      check($sformatf("lock_gnt_%0d", k), {31'b0, bus.ld_gnt}, 32'h1);
      check($sformatf("lock_stall_%0d", k), {31'b0, bus.core_stall}, 32'h1);
      check($sformatf("lock_addr_%0d", k), bus.mem_addr, 32'h40 + 32'(4 * k));
      @(posedge clk); #1;
    end
    bus.ld_req = 0; bus.ld_lock = 0; bus.ld_we = 0;
    @(negedge clk);
    check("unlock_core_stall", {31'b0, bus.core_stall}, 32'h0);
    check("unlock_core_we0", {31'b0, bus.mem_we0}, 32'h1);
    check("unlock_core_addr", bus.mem_addr, 32'h30);
    @(posedge clk); #1;
    bus.core_req = 0; bus.core_we = 0;
    ld_read(32'h4C, 32'hB0000003, "ldr4c");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
